// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone master bridge: latches a request, drives one bus
// cycle, and handles ack/err/retry/timeout before returning a one-cycle pulse.
module wb_master_bridge #(
    parameter int DATA_W    = 32,
    parameter int ADR_W     = 32,
    parameter int SEL_W     = DATA_W / 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2,
    parameter int RETRY_GAP = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wbm_req_i,
    input  logic              wbm_we_i,
    input  logic [ADR_W-1:0]  wbm_adr_i,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic [SEL_W-1:0]  wbm_sel_i,
    output logic [DATA_W-1:0] wbm_dat_o,
    output logic              wbm_ack_o,
    output logic              wbm_err_o,
    output logic              wbm_busy_o,
    input  logic [DATA_W-1:0] wbs_dat_i,
    input  logic              wbs_ack_i,
    input  logic              wbs_err_i,
    input  logic              wbs_rty_i,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic [ADR_W-1:0]  wbs_adr_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic [SEL_W-1:0]  wbs_sel_o,
    output logic              wbs_we_o
);
    // Zero-valued parameters would give zero-width counters; keep at least one bit.
    localparam int TMO_W = (TIMEOUT > 0)   ? $clog2(TIMEOUT + 1)   : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, BACKOFF, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            rty_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (wbm_req_i) begin
                    adr_d   = wbm_adr_i;
                    wdat_d  = wbm_dat_i;
                    sel_d   = wbm_sel_i;
                    we_d    = wbm_we_i;
                    tmo_d   = '0;
                    rty_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (wbs_err_i) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (wbs_ack_i) begin
                    ack_d   = 1'b1;
                    if (!we_q) rdat_d = wbs_dat_i;
                    state_d = RESP;
                end else if (wbs_rty_i) begin
                    if (rty_q < RTY_W'(MAX_RETRY)) begin
                        rty_d   = rty_q + RTY_W'(1);
                        gap_d   = '0;
                        state_d = BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // Fires on the cycle the counter would reach TIMEOUT, so the
                    // bus stays up for exactly TIMEOUT cycles.
                    if ((TIMEOUT > 0) && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BACKOFF: begin
                if (gap_q == GAP_W'(RETRY_GAP - 1)) begin
                    tmo_d   = '0;
                    gap_d   = '0;
                    state_d = ACTIVE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            RESP: begin
                tmo_d   = '0;
                rty_d   = '0;
                gap_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // cyc/stb decode straight from state so an async reset drops them at once.
    assign wbs_cyc_o  = (state_q == ACTIVE);
    assign wbs_stb_o  = (state_q == ACTIVE);
    assign wbs_adr_o  = adr_q;
    assign wbs_dat_o  = wdat_q;
    assign wbs_sel_o  = sel_q;
    assign wbs_we_o   = we_q;
    assign wbm_dat_o  = rdat_q;
    assign wbm_ack_o  = ack_q;
    assign wbm_err_o  = err_q;
    assign wbm_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: slave responses are driven by hand and
// every observation is compared against hand-computed values.
module tb_wb_master_bridge;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wbm_req_i, wbm_we_i;
    logic [31:0] wbm_adr_i, wbm_dat_i;
    logic [3:0]  wbm_sel_i;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_busy_o;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic        wbs_cyc_o, wbs_stb_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o;

    int checks = 0;
    int errors = 0;

    wb_master_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wbm_req_i(wbm_req_i), .wbm_we_i(wbm_we_i), .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_busy_o(wbm_busy_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the master-side pulse/busy triple in one call.
    task automatic chk_m(input string tag, input logic ack, input logic err, input logic busy);
        chk({tag, ".ack"}, 64'(wbm_ack_o), 64'(ack));
        chk({tag, ".err"}, 64'(wbm_err_o), 64'(err));
        chk({tag, ".busy"}, 64'(wbm_busy_o), 64'(busy));
    endtask

    task automatic chk_bus(input string tag, input logic on);
        chk({tag, ".cyc"}, 64'(wbs_cyc_o), 64'(on));
        chk({tag, ".stb"}, 64'(wbs_stb_o), 64'(on));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        wbm_req_i = 0; wbm_we_i = 0; wbm_adr_i = 0; wbm_dat_i = 0; wbm_sel_i = 0;
        wbs_dat_i = 0; wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0;
        tick(); tick();
        chk_bus("rst", 1'b0);
        chk_m("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.dat_o", 64'(wbm_dat_o), 64'h0);
        chk("rst.adr_o", 64'(wbs_adr_o), 64'h0);

        // Write, request present on the first edge after reset release
        rst_ni = 1'b1;
        wbm_req_i = 1; wbm_we_i = 1; wbm_adr_i = 32'h100; wbm_dat_i = 32'hDEADBEEF; wbm_sel_i = 4'hF;
        tick();
        chk_bus("wr.a1", 1'b1);
        chk("wr.adr", 64'(wbs_adr_o), 64'h100);
        chk("wr.dat", 64'(wbs_dat_o), 64'hDEADBEEF);
        chk("wr.sel", 64'(wbs_sel_o), 64'hF);
        chk("wr.we", 64'(wbs_we_o), 64'h1);
        chk_m("wr.a1", 1'b0, 1'b0, 1'b1);
        wbm_req_i = 0; wbm_adr_i = 32'h999; wbm_we_i = 0; wbm_dat_i = 32'h0; wbm_sel_i = 4'h1;
        tick();
        chk_bus("wr.a2", 1'b1);
        chk("wr.adr_hold", 64'(wbs_adr_o), 64'h100);
        chk("wr.we_hold", 64'(wbs_we_o), 64'h1);
        wbs_ack_i = 1; wbs_dat_i = 32'hBAD0BAD0;
        tick();
        wbs_ack_i = 0;
        chk_bus("wr.resp", 1'b0);
        chk_m("wr.resp", 1'b1, 1'b0, 1'b1);
        chk("wr.dat_o", 64'(wbm_dat_o), 64'h0);
        tick();
        chk_m("wr.idle", 1'b0, 1'b0, 1'b0);

        // Read
        wbm_req_i = 1; wbm_we_i = 0; wbm_adr_i = 32'h200; wbm_sel_i = 4'hF;
        tick();
        wbm_req_i = 0;
        chk_bus("rd.a1", 1'b1);
        chk("rd.adr", 64'(wbs_adr_o), 64'h200);
        chk("rd.we", 64'(wbs_we_o), 64'h0);
        wbs_ack_i = 1; wbs_dat_i = 32'h12345678;
        tick();
        wbs_ack_i = 0; wbs_dat_i = 32'h0;
        chk_m("rd.resp", 1'b1, 1'b0, 1'b1);
        chk("rd.dat_o", 64'(wbm_dat_o), 64'h12345678);
        tick();
        chk_m("rd.idle", 1'b0, 1'b0, 1'b0);
        chk("rd.dat_hold", 64'(wbm_dat_o), 64'h12345678);

        // Retry: rty held high, also exercises rty ignored during BACKOFF
        wbm_req_i = 1; wbm_we_i = 1; wbm_adr_i = 32'h300; wbm_dat_i = 32'h55AA55AA;
        tick();
        wbm_req_i = 0;
        chk_bus("rty.i1", 1'b1);
        wbs_rty_i = 1;
        tick(); chk_bus("rty.b1a", 1'b0); chk_m("rty.b1a", 1'b0, 1'b0, 1'b1);
        tick(); chk_bus("rty.b1b", 1'b0);
        tick(); chk_bus("rty.i2", 1'b1); chk("rty.adr2", 64'(wbs_adr_o), 64'h300);
        tick(); chk_bus("rty.b2a", 1'b0);
        tick(); chk_bus("rty.b2b", 1'b0); chk_m("rty.b2b", 1'b0, 1'b0, 1'b1);
        tick(); chk_bus("rty.i3", 1'b1); chk("rty.dat3", 64'(wbs_dat_o), 64'h55AA55AA);
        tick();
        wbs_rty_i = 0;
        chk_bus("rty.resp", 1'b0);
        chk_m("rty.resp", 1'b0, 1'b1, 1'b1);
        tick();
        chk_m("rty.idle", 1'b0, 1'b0, 1'b0);

        // Timeout: bus up exactly 16 cycles, then err
        wbm_req_i = 1; wbm_we_i = 0; wbm_adr_i = 32'h400;
        tick();
        wbm_req_i = 0;
        for (int i = 1; i < 16; i++) begin
            chk_bus($sformatf("tmo.c%0d", i), 1'b1);
            tick();
        end
        chk_bus("tmo.c16", 1'b1);
        chk_m("tmo.c16", 1'b0, 1'b0, 1'b1);
        tick();
        chk_bus("tmo.resp", 1'b0);
        chk_m("tmo.resp", 1'b0, 1'b1, 1'b1);
        chk("tmo.dat_o", 64'(wbm_dat_o), 64'h12345678);
        tick();
        chk_m("tmo.idle", 1'b0, 1'b0, 1'b0);

        // Timeout boundary: ack on cycle 16 wins
        wbm_req_i = 1; wbm_we_i = 0; wbm_adr_i = 32'h404;
        tick();
        wbm_req_i = 0;
        for (int i = 1; i < 16; i++) tick();
        chk_bus("tmo2.c16", 1'b1);
        wbs_ack_i = 1; wbs_dat_i = 32'hCAFEF00D;
        tick();
        wbs_ack_i = 0; wbs_dat_i = 32'h0;
        chk_m("tmo2.resp", 1'b1, 1'b0, 1'b1);
        chk("tmo2.dat_o", 64'(wbm_dat_o), 64'hCAFEF00D);
        tick();

        // ack+err -> err only, read data not captured
        wbm_req_i = 1; wbm_we_i = 0; wbm_adr_i = 32'h500;
        tick();
        wbm_req_i = 0;
        wbs_ack_i = 1; wbs_err_i = 1; wbs_dat_i = 32'h11112222;
        tick();
        wbs_ack_i = 0; wbs_err_i = 0;
        chk_m("ae.resp", 1'b0, 1'b1, 1'b1);
        chk("ae.dat_o", 64'(wbm_dat_o), 64'hCAFEF00D);
        tick();

        // ack+rty -> ack only; request held through RESP restarts 2 cycles after ack
        wbm_req_i = 1; wbm_we_i = 0; wbm_adr_i = 32'h600;
        tick();
        chk_bus("ar.a1", 1'b1);
        wbs_ack_i = 1; wbs_rty_i = 1; wbs_dat_i = 32'h33334444;
        tick();
        wbs_ack_i = 0; wbs_rty_i = 0;
        chk_m("ar.resp", 1'b1, 1'b0, 1'b1);
        chk("ar.dat_o", 64'(wbm_dat_o), 64'h33334444);
        wbs_ack_i = 1;
        tick();
        wbs_ack_i = 0;
        chk_bus("hold.idle", 1'b0);
        chk_m("hold.idle", 1'b0, 1'b0, 1'b0);
        tick();
        wbm_req_i = 0;
        chk_bus("hold.a1", 1'b1);
        wbs_ack_i = 1;
        tick();
        wbs_ack_i = 0;
        chk_m("hold.resp", 1'b1, 1'b0, 1'b1);
        tick();

        // Reset during ACTIVE
        wbm_req_i = 1; wbm_we_i = 1; wbm_adr_i = 32'h700;
        tick();
        wbm_req_i = 0;
        chk_bus("rstm.a1", 1'b1);
        rst_ni = 1'b0;
        #1;
        chk_bus("rstm.async", 1'b0);
        chk_m("rstm.async", 1'b0, 1'b0, 1'b0);
        chk("rstm.adr", 64'(wbs_adr_o), 64'h0);
        wbs_ack_i = 1;
        tick();
        wbs_ack_i = 0;
        chk_m("rstm.held", 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        wbm_req_i = 1; wbm_adr_i = 32'h704;
        tick();
        wbm_req_i = 0;
        chk_bus("rstm.req", 1'b1);
        chk("rstm.adr2", 64'(wbs_adr_o), 64'h704);
        wbs_ack_i = 1;
        tick();
        wbs_ack_i = 0;
        chk_m("rstm.resp", 1'b1, 1'b0, 1'b1);
        tick();
        chk_m("rstm.idle", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
